// File: rtl/se_arb_pkg.sv
// Shared types for the search-engine lookup arbiter: field widths, the queued
// request entry and the one-hot arbiter FSM encoding.
package se_arb_pkg;

    localparam int MAC_W  = 48;
    localparam int HASH_W = 10;
    localparam int PMAP_W = 16;
    localparam int RES_W  = 16;

    typedef struct packed {
        logic [MAC_W-1:0]  mac;
        logic [HASH_W-1:0] hash;
        logic              source;
        logic [PMAP_W-1:0] portmap;
    } req_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ISSUE = 3'b010,
        ST_WAIT  = 3'b100
    } arb_state_e;

endpackage

// File: rtl/se_lookup_arbiter_if.sv
// Bundle of the frame-processor request/response bus and the search-engine bus.
// master = arbiter side, slave = frame processors plus engine (environment side).
interface se_lookup_arbiter_if #(
    parameter int NREQ = 4
) ();
    import se_arb_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*MAC_W-1:0]  req_mac;
    logic [NREQ*HASH_W-1:0] req_hash;
    logic [NREQ-1:0]        req_source;
    logic [NREQ*PMAP_W-1:0] req_portmap;
    logic [NREQ-1:0]        rsp_ack;
    logic [NREQ-1:0]        rsp_nak;
    logic [RES_W-1:0]       rsp_result;
    logic                   se_req;
    logic [MAC_W-1:0]       se_mac;
    logic [HASH_W-1:0]      se_hash;
    logic                   se_source;
    logic [PMAP_W-1:0]      source_portmap;
    logic                   se_ack;
    logic                   se_nak;
    logic [RES_W-1:0]       se_result;
    logic [NREQ-1:0]        q_ovf;
    logic                   se_timeout;

    modport master (
        input  req_valid, req_mac, req_hash, req_source, req_portmap,
        input  se_ack, se_nak, se_result,
        output rsp_ack, rsp_nak, rsp_result,
        output se_req, se_mac, se_hash, se_source, source_portmap,
        output q_ovf, se_timeout
    );

    modport slave (
        output req_valid, req_mac, req_hash, req_source, req_portmap,
        output se_ack, se_nak, se_result,
        input  rsp_ack, rsp_nak, rsp_result,
        input  se_req, se_mac, se_hash, se_source, source_portmap,
        input  q_ovf, se_timeout
    );
endinterface

// File: rtl/se_arb_req_queue.sv
// Per-port request FIFO. The head is read combinationally so the arbiter can
// grant and capture an entry in the same cycle it becomes eligible.
module se_arb_req_queue
    import se_arb_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  req_entry_t push_entry,
    output req_entry_t head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(QDEPTH);

    req_entry_t    mem [QDEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == (AW+1)'(QDEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop && !empty;
    // A full queue still accepts a push when its head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end
endmodule

// File: rtl/se_lookup_arbiter.sv
// Round-robin arbiter sharing one MAC search engine between NREQ frame processors.
// Optional engine watchdog enabled by defining SE_ARB_TIMEOUT_EN.
module se_lookup_arbiter
    import se_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int QDEPTH  = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    se_lookup_arbiter_if.master bus
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW-1:0] LAST_PORT = PW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("se_lookup_arbiter: NREQ must be 2..8");
    end
    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("se_lookup_arbiter: QDEPTH must be a power of 2, >= 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("se_lookup_arbiter: TIMEOUT must be >= 2");
    end

    arb_state_e       state_reg, state_next;
    logic [PW-1:0]    rr_ptr_reg;
    logic [PW-1:0]    grant_reg;
    logic [PW-1:0]    grant_idx;
    logic             grant_found;
    logic             grant_fire;
    logic             rsp_busy;
    logic             eng_done;
    logic             wd_expire;
    req_entry_t       issue_reg;
    req_entry_t       push_entry [NREQ];
    req_entry_t       head       [NREQ];
    logic [NREQ-1:0]  q_full, q_empty, pop, ovf_set;
    logic [NREQ-1:0]  rsp_ack_reg, rsp_nak_reg, rsp_ack_next, rsp_nak_next;
    logic [NREQ-1:0]  q_ovf_reg;
    logic [RES_W-1:0] rsp_result_reg;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
        assign push_entry[gi] = '{
            mac:     bus.req_mac[gi*MAC_W +: MAC_W],
            hash:    bus.req_hash[gi*HASH_W +: HASH_W],
            source:  bus.req_source[gi],
            portmap: bus.req_portmap[gi*PMAP_W +: PMAP_W]
        };
        assign pop[gi]     = grant_fire && (grant_idx == PW'(gi));
        assign ovf_set[gi] = bus.req_valid[gi] && q_full[gi] && !pop[gi];

        se_arb_req_queue #(.QDEPTH(QDEPTH)) u_queue (
            .clk        (clk),
            .rst        (rst),
            .push       (bus.req_valid[gi]),
            .pop        (pop[gi]),
            .push_entry (push_entry[gi]),
            .head       (head[gi]),
            .full       (q_full[gi]),
            .empty      (q_empty[gi])
        );
    end

    // First non-empty queue at or after the round-robin pointer.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!grant_found && !q_empty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    assign eng_done = bus.se_ack || bus.se_nak;
    // Hold off a new grant while the response pulse is out so issue spacing is a+3.
    assign rsp_busy = |(rsp_ack_reg | rsp_nak_reg);

    always_comb begin
        state_next   = state_reg;
        grant_fire   = 1'b0;
        rsp_ack_next = '0;
        rsp_nak_next = '0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_found && !rsp_busy) begin
                    grant_fire = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (eng_done) begin
                    state_next = ST_IDLE;
                    if (bus.se_ack && !bus.se_nak) begin
                        rsp_ack_next[grant_reg] = 1'b1;
                    end else begin
                        rsp_nak_next[grant_reg] = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_next              = ST_IDLE;
                    rsp_nak_next[grant_reg] = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            grant_reg      <= '0;
            issue_reg      <= '0;
            rsp_ack_reg    <= '0;
            rsp_nak_reg    <= '0;
            rsp_result_reg <= '0;
            q_ovf_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            rsp_ack_reg <= rsp_ack_next;
            rsp_nak_reg <= rsp_nak_next;
            q_ovf_reg   <= q_ovf_reg | ovf_set;
            if (grant_fire) begin
                issue_reg <= head[grant_idx];
                grant_reg <= grant_idx;
            end
            if (state_reg == ST_WAIT && (eng_done || wd_expire)) begin
                rsp_result_reg <= eng_done ? bus.se_result : '0;
                rr_ptr_reg     <= (grant_reg == LAST_PORT) ? '0 : grant_reg + 1'b1;
            end
        end
    end

`ifdef SE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_cnt_reg;
    logic          se_timeout_reg;

    // Counter equals the number of WAIT cycles seen so far, including this one.
    assign wd_expire = (state_reg == ST_WAIT) && (wd_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg     <= '0;
            se_timeout_reg <= 1'b0;
        end else begin
            if (state_reg == ST_ISSUE) begin
                wd_cnt_reg <= CW'(1);
            end else if (state_reg == ST_WAIT) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
            if (wd_expire && !eng_done) begin
                se_timeout_reg <= 1'b1;
            end
        end
    end

    assign bus.se_timeout = se_timeout_reg;
`else
    assign wd_expire      = 1'b0;
    assign bus.se_timeout = 1'b0;
`endif

    assign bus.rsp_ack        = rsp_ack_reg;
    assign bus.rsp_nak        = rsp_nak_reg;
    assign bus.rsp_result     = rsp_result_reg;
    assign bus.se_req         = (state_reg == ST_ISSUE);
    assign bus.se_mac         = issue_reg.mac;
    assign bus.se_hash        = issue_reg.hash;
    assign bus.se_source      = issue_reg.source;
    assign bus.source_portmap = issue_reg.portmap;
    assign bus.q_ovf          = q_ovf_reg;
endmodule

// File: tb/tb_se_lookup_arbiter.sv
// Self-checking bench for se_lookup_arbiter: queue/round-robin reference model with
// a simple engine responder; timeout scenario runs only with SE_ARB_TIMEOUT_EN.
module tb_se_lookup_arbiter;
    import se_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int QDEPTH  = 2;
    localparam int TIMEOUT = 64;

    typedef struct {
        int         port;
        req_entry_t e;
    } push_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    se_lookup_arbiter_if #(.NREQ(NREQ)) bus ();

    se_lookup_arbiter #(.NREQ(NREQ), .QDEPTH(QDEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state
    req_entry_t      mq [NREQ][$];
    push_t           pend[$];
    int              rr, busy_port, issue_cyc, last_resp_cyc, reply_cyc, n_accept;
    req_entry_t      issued;
    logic [NREQ-1:0] exp_ovf, exp_ack, exp_nak;
    logic [15:0]     exp_res;
    bit              exp_valid, exp_to;

    // Drive values for the current cycle
    logic [NREQ-1:0] drv_valid;
    req_entry_t      drv_e [NREQ];
    logic            drv_ack, drv_nak;
    logic [15:0]     drv_res;

    // Engine behaviour: mode 0 ack, 1 nak, 2 both, 3 random
    int eng_delay  = 2;
    int eng_mode   = 0;
    int eng_res    = -1;
    bit eng_silent = 1'b0;

    // Observation logs
    int          grant_log[$];
    bit          src_log[$];
    int          iss_cyc_log[$];
    logic [47:0] iss_mac_log[$];
    int          rsp_port_log[$];
    bit          rsp_nak_log[$];
    logic [15:0] rsp_res_log[$];
    int          rsp_cyc_log[$];

    task automatic apply_drive();
        bus.req_valid = drv_valid;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_mac[i*MAC_W +: MAC_W]       = drv_e[i].mac;
            bus.req_hash[i*HASH_W +: HASH_W]    = drv_e[i].hash;
            bus.req_source[i]                   = drv_e[i].source;
            bus.req_portmap[i*PMAP_W +: PMAP_W] = drv_e[i].portmap;
        end
        bus.se_ack    = drv_ack;
        bus.se_nak    = drv_nak;
        bus.se_result = drv_res;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        pend.delete();
        rr = 0; busy_port = -1; issue_cyc = 0; last_resp_cyc = -100; reply_cyc = 0; n_accept = 0;
        exp_ovf = '0; exp_ack = '0; exp_nak = '0; exp_res = '0; exp_valid = 0; exp_to = 0;
        drv_valid = '0; drv_ack = 0; drv_nak = 0; drv_res = '0;
        grant_log.delete(); src_log.delete(); iss_cyc_log.delete(); iss_mac_log.delete();
        rsp_port_log.delete(); rsp_nak_log.delete(); rsp_res_log.delete(); rsp_cyc_log.delete();
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        drv_valid = '0; drv_ack = 0; drv_nak = 0;
        apply_drive();
        repeat (n) @(posedge clk);
        @(negedge clk);
        cyc += n;
        model_reset();
        apply_drive();
    endtask

    task automatic send(int p, bit src);
        drv_valid[p]       = 1'b1;
        drv_e[p].mac       = {16'($urandom), 32'($urandom)};
        drv_e[p].hash      = 10'($urandom);
        drv_e[p].source    = src;
        drv_e[p].portmap   = 16'($urandom);
    endtask

    // One clock: model the edge, advance, then check every output of the new cycle.
    task automatic step();
        bit want_req;
        int p;
        for (int i = 0; i < NREQ; i++) begin
            if (drv_valid[i]) pend.push_back('{port: i, e: drv_e[i]});
        end
        if ((drv_ack || drv_nak) && busy_port >= 0) begin
            exp_ack = '0; exp_nak = '0;
            if (drv_ack && !drv_nak) exp_ack[busy_port] = 1'b1;
            else exp_nak[busy_port] = 1'b1;
            exp_res = drv_res; exp_valid = 1;
            rr = (busy_port + 1) % NREQ; last_resp_cyc = cyc; busy_port = -1;
        end
`ifdef SE_ARB_TIMEOUT_EN
        else if (busy_port >= 0 && cyc == issue_cyc + TIMEOUT - 1) begin
            exp_ack = '0; exp_nak = '0;
            exp_nak[busy_port] = 1'b1;
            exp_res = '0; exp_valid = 1; exp_to = 1;
            rr = (busy_port + 1) % NREQ; last_resp_cyc = cyc; busy_port = -1;
        end
`endif
        apply_drive();
        @(posedge clk);
        @(negedge clk);
        cyc++;

        checks++;
        if (bus.rsp_ack !== exp_ack) begin
            errors++; $display("FAIL rsp_ack cyc=%0d: got %b want %b", cyc, bus.rsp_ack, exp_ack);
        end
        checks++;
        if (bus.rsp_nak !== exp_nak) begin
            errors++; $display("FAIL rsp_nak cyc=%0d: got %b want %b", cyc, bus.rsp_nak, exp_nak);
        end
        if (exp_valid) begin
            checks++;
            if (bus.rsp_result !== exp_res) begin
                errors++; $display("FAIL rsp_result cyc=%0d: got %h want %h", cyc, bus.rsp_result, exp_res);
            end
        end
        if ((bus.rsp_ack | bus.rsp_nak) !== '0) begin
            p = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (bus.rsp_ack[i] === 1'b1 || bus.rsp_nak[i] === 1'b1) p = i;
            rsp_port_log.push_back(p);
            rsp_nak_log.push_back(|bus.rsp_nak);
            rsp_res_log.push_back(bus.rsp_result);
            rsp_cyc_log.push_back(cyc);
            $display("rsp   cyc=%0d port=%0d %s result=%h", cyc, p, (|bus.rsp_nak) ? "nak" : "ack", bus.rsp_result);
        end
        exp_ack = '0; exp_nak = '0; exp_valid = 0;

        want_req = 0;
        if (busy_port < 0 && cyc >= last_resp_cyc + 3) begin
            for (int i = 0; i < NREQ; i++) if (mq[i].size() > 0) want_req = 1;
        end
        checks++;
        if (bus.se_req !== want_req) begin
            errors++; $display("FAIL se_req cyc=%0d: got %b want %b", cyc, bus.se_req, want_req);
        end
        if (bus.se_req === 1'b1 && want_req) begin
            p = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (p < 0 && mq[(rr + k) % NREQ].size() > 0) p = (rr + k) % NREQ;
            end
            issued    = mq[p].pop_front();
            busy_port = p;
            issue_cyc = cyc;
            reply_cyc = cyc + eng_delay;
            grant_log.push_back(p);
            src_log.push_back(issued.source);
            iss_cyc_log.push_back(cyc);
            iss_mac_log.push_back(bus.se_mac);
            $display("issue cyc=%0d port=%0d mac=%h src=%0b", cyc, p, bus.se_mac, bus.se_source);
        end
        if (busy_port >= 0) begin
            checks++;
            if ({bus.se_mac, bus.se_hash, bus.se_source, bus.source_portmap} !== issued) begin
                errors++;
                $display("FAIL se_fields cyc=%0d: got %h/%h/%b/%h want %h/%h/%b/%h", cyc,
                         bus.se_mac, bus.se_hash, bus.se_source, bus.source_portmap,
                         issued.mac, issued.hash, issued.source, issued.portmap);
            end
        end

        while (pend.size() > 0) begin
            push_t x;
            x = pend.pop_front();
            if (mq[x.port].size() < QDEPTH) begin
                mq[x.port].push_back(x.e);
                n_accept++;
            end else begin
                exp_ovf[x.port] = 1'b1;
            end
        end
        checks++;
        if (bus.q_ovf !== exp_ovf) begin
            errors++; $display("FAIL q_ovf cyc=%0d: got %b want %b", cyc, bus.q_ovf, exp_ovf);
        end
        checks++;
        if (bus.se_timeout !== exp_to) begin
            errors++; $display("FAIL se_timeout cyc=%0d: got %b want %b", cyc, bus.se_timeout, exp_to);
        end

        drv_valid = '0; drv_ack = 0; drv_nak = 0; drv_res = 16'($urandom);
        if (busy_port >= 0 && !eng_silent && cyc == reply_cyc) begin
            int m;
            drv_res = (eng_res >= 0) ? eng_res[15:0] : 16'($urandom);
            m = (eng_mode == 3) ? int'($urandom_range(0, 2)) : eng_mode;
            drv_ack = (m == 0 || m == 2);
            drv_nak = (m == 1 || m == 2);
        end
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic drain();
        int guard;
        bit idle;
        guard = 0;
        idle  = 0;
        while (!idle && guard < 600) begin
            step();
            guard++;
            idle = (busy_port < 0) && (pend.size() == 0) && (drv_ack == 0) && (drv_nak == 0);
            for (int i = 0; i < NREQ; i++) if (mq[i].size() > 0) idle = 0;
        end
        run(3);
        checks++;
        if (!idle) begin
            errors++; $display("FAIL drain_bound: got busy after %0d cycles want idle", guard);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        rst = 1'b1;
        @(posedge clk); @(negedge clk); cyc++;
        checks++; if (bus.rsp_ack !== '0)  begin errors++; $display("FAIL reset_rsp_ack: got %b want 0", bus.rsp_ack); end
        checks++; if (bus.rsp_nak !== '0)  begin errors++; $display("FAIL reset_rsp_nak: got %b want 0", bus.rsp_nak); end
        checks++; if (bus.rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result: got %h want 0", bus.rsp_result); end
        checks++; if (bus.se_req !== 1'b0) begin errors++; $display("FAIL reset_se_req: got %b want 0", bus.se_req); end
        checks++; if (bus.se_mac !== '0)   begin errors++; $display("FAIL reset_se_mac: got %h want 0", bus.se_mac); end
        checks++; if (bus.se_hash !== '0)  begin errors++; $display("FAIL reset_se_hash: got %h want 0", bus.se_hash); end
        checks++; if (bus.se_source !== 1'b0) begin errors++; $display("FAIL reset_se_source: got %b want 0", bus.se_source); end
        checks++; if (bus.source_portmap !== '0) begin errors++; $display("FAIL reset_portmap: got %h want 0", bus.source_portmap); end
        checks++; if (bus.q_ovf !== '0)    begin errors++; $display("FAIL reset_q_ovf: got %b want 0", bus.q_ovf); end
        checks++; if (bus.se_timeout !== 1'b0) begin errors++; $display("FAIL reset_se_timeout: got %b want 0", bus.se_timeout); end
        rst = 1'b0;
        run(3);
    endtask

    task automatic test_single();
        int t;
        do_reset(2);
        rst = 1'b0;
        eng_delay = 3; eng_mode = 0; eng_res = 16'h0004;
        send(1, 1'b0);
        drv_e[1].mac = 48'h0011_2233_4455;
        t = cyc;
        step();
        run(10);
        checks++;
        if (iss_cyc_log.size() != 1 || iss_cyc_log[0] != t + 2) begin
            errors++; $display("FAIL single_issue_cycle: got n=%0d want one at %0d", iss_cyc_log.size(), t + 2);
        end else begin
            checks++;
            if (iss_mac_log[0] !== 48'h0011_2233_4455) begin
                errors++; $display("FAIL single_mac: got %h want 001122334455", iss_mac_log[0]);
            end
        end
        checks++;
        if (rsp_cyc_log.size() != 1 || rsp_cyc_log[0] != t + 6 || rsp_port_log[0] != 1
            || rsp_nak_log[0] || rsp_res_log[0] !== 16'h0004) begin
            errors++; $display("FAIL single_rsp: got n=%0d want ack port 1 result 0004 at %0d", rsp_cyc_log.size(), t + 6);
        end
        eng_res = -1;
    endtask

    task automatic test_round_robin();
        do_reset(2);
        rst = 1'b0;
        eng_delay = 2; eng_mode = 0;
        send(0, 1'b0); send(2, 1'b0); send(3, 1'b0);
        step();
        run(20);
        checks++;
        if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 2 || grant_log[2] != 3) begin
            errors++; $display("FAIL rr_order: got %p want 0,2,3", grant_log);
        end
        send(1, 1'b0);
        step();
        run(10);
        checks++;
        if (grant_log.size() != 4 || grant_log[3] != 1) begin
            errors++; $display("FAIL rr_port1: got %p want 0,2,3,1", grant_log);
        end
    endtask

    task automatic test_order();
        do_reset(2);
        rst = 1'b0;
        eng_delay = 12; eng_mode = 0;
        send(1, 1'b0);
        step(); step();
        send(0, 1'b0);
        step();
        run(5);
        send(0, 1'b1);
        step();
        run(60);
        checks++;
        if (grant_log.size() != 3 || grant_log[0] != 1 || grant_log[1] != 0 || grant_log[2] != 0
            || src_log[1] != 1'b0 || src_log[2] != 1'b1) begin
            errors++; $display("FAIL port_order: got grants %p sources %p want 1,0,0 / x,0,1", grant_log, src_log);
        end
        eng_delay = 2;
    endtask

    task automatic test_overflow();
        int n2;
        do_reset(2);
        rst = 1'b0;
        eng_delay = 25; eng_mode = 0;
        send(3, 1'b0);
        step();
        run(3);
        send(2, 1'b0); step(); step();
        send(2, 1'b1); step(); step();
        send(2, 1'b1); step();
        eng_delay = 2;
        checks++;
        if (bus.q_ovf !== 4'b0100) begin
            errors++; $display("FAIL ovf_flag: got %b want 0100", bus.q_ovf);
        end
        drain();
        n2 = 0;
        foreach (rsp_port_log[i]) if (rsp_port_log[i] == 2) n2++;
        checks++;
        if (n2 != 2) begin
            errors++; $display("FAIL ovf_responses: got %0d want 2", n2);
        end
    endtask

    task automatic test_both_and_spurious();
        do_reset(2);
        rst = 1'b0;
        eng_delay = 2; eng_mode = 2;
        send(0, 1'b0);
        step();
        run(8);
        checks++;
        if (rsp_nak_log.size() != 1 || !rsp_nak_log[0] || rsp_port_log[0] != 0) begin
            errors++; $display("FAIL ack_and_nak: got n=%0d want single nak on port 0", rsp_nak_log.size());
        end
        eng_mode = 0;
        drv_ack = 1'b1; drv_res = 16'hbeef;
        step();
        run(3);
        checks++;
        if (rsp_port_log.size() != 1) begin
            errors++; $display("FAIL spurious_ack: got %0d responses want 1", rsp_port_log.size());
        end
    endtask

    task automatic test_random();
        do_reset(2);
        rst = 1'b0;
        eng_mode = 3;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) send(i, 1'($urandom));
            end
            eng_delay = $urandom_range(1, 6);
            step();
        end
        eng_delay = 2;
        drain();
        checks++;
        if (rsp_port_log.size() != n_accept) begin
            errors++; $display("FAIL random_count: got %0d responses want %0d", rsp_port_log.size(), n_accept);
        end
        eng_mode = 0;
    endtask

    task automatic test_reset_mid_wait();
        do_reset(2);
        rst = 1'b0;
        eng_silent = 1'b1;
        send(2, 1'b1);
        step();
        run(6);
        do_reset(1);
        rst = 1'b0;
        eng_silent = 1'b0;
        drv_ack = 1'b1; drv_res = 16'h1234;
        step();
        run(3);
        checks++;
        if (rsp_port_log.size() != 0) begin
            errors++; $display("FAIL late_ack: got %0d responses want 0", rsp_port_log.size());
        end
        checks++;
        if ({bus.se_mac, bus.se_hash, bus.se_source, bus.source_portmap} !== '0 || bus.rsp_result !== '0) begin
            errors++; $display("FAIL mid_wait_reset: got mac %h result %h want 0", bus.se_mac, bus.rsp_result);
        end
    endtask

`ifdef SE_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset(2);
        rst = 1'b0;
        eng_silent = 1'b1;
        send(1, 1'b0);
        step();
        run(TIMEOUT + 6);
        checks++;
        if (rsp_cyc_log.size() != 1 || iss_cyc_log.size() != 1 || rsp_cyc_log[0] != iss_cyc_log[0] + TIMEOUT
            || !rsp_nak_log[0] || rsp_res_log[0] !== 16'h0000) begin
            errors++; $display("FAIL timeout_rsp: got n=%0d want nak result 0 at issue+%0d", rsp_cyc_log.size(), TIMEOUT);
        end
        checks++;
        if (bus.se_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_flag: got %b want 1", bus.se_timeout);
        end
        eng_silent = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < NREQ; i++) drv_e[i] = '0;
        model_reset();
        apply_drive();
        test_reset();
        test_single();
        test_round_robin();
        test_order();
        test_overflow();
        test_both_and_spurious();
        test_random();
        test_reset_mid_wait();
`ifdef SE_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
